sink_nch_ctrl: RTL and testbench
================================

# sink_nch_ctrl

Parametrised drain controller for the output side of the interpolator chain. It empties up to `NCH` lock-stepped output FIFOs (I/Q or wider) into sample memories. It generates the shared FIFO read strobe, the memory write strobe and address, and completion status. It generalises the single-pair simulation sink in three ways: any channel count with a per-channel enable mask, a circular capture mode with wrap signalling, and a clean abort.

## Interface
Parameters:
- `NCH`, 2, number of lock-stepped channels (FIFOs) drained together
- `ADDR_WIDTH`, 20, memory address / length counter width
- `FIFO_RD_LAT`, 1, cycles from FIFO read strobe to valid FIFO output (1 or 2)

Ports:
- `clk`  in  1  single clock
- `rstn`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  one-cycle pulse, begins a capture (sampled only in IDLE)
- `stop_i`  in  1  level/pulse abort request
- `mode_i`  in  1  0 = one-shot, 1 = circular; sampled at start
- `ch_en_i`  in  NCH  channel enable mask; sampled at start
- `empty_i`  in  NCH  per-channel FIFO empty flags
- `len_i`  in  ADDR_WIDTH  words per capture (addresses 0..len_i-1); sampled at start
- `Read_Enable_o`  out  1  shared read strobe to all FIFOs
- `Write_Enable_o`  out  1  shared write strobe to all sample memories
- `addr_o`  out  ADDR_WIDTH  memory write address, valid with `Write_Enable_o`
- `count_o`  out  ADDR_WIDTH  writes completed in the current pass
- `busy_o`  out  1  high from accepted start until DONE
- `done_o`  out  1  one-cycle completion pulse
- `wrap_o`  out  1  one-cycle pulse on the write to address len-1 in circular mode

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on `start_i`, latch `len_i`, `mode_i` and `ch_en_i`, clear the counters, and go to RUN. If the latched len = 0, go straight to DONE.
- RUN: `Read_Enable_o` = RUN & ~stop_i & ~(|(empty_i & ch_en_q)) & (one-shot ? rd_cnt < len : 1). It is combinational from registered state and inputs.
  - Disabled channels never stall the read. Their FIFOs still receive the shared strobe.
- Each read increments `rd_cnt`.
  - Circular mode: `rd_cnt` wraps from len-1 to 0.
  - One-shot mode: once `rd_cnt` = len, go to DRAIN.
- `stop_i` high in RUN: stop issuing reads and go to DRAIN.
- DRAIN: wait until every read in flight (at most `FIFO_RD_LAT`) has produced its write, then go to DONE.
- DONE: pulse `done_o` for 1 cycle, drop `busy_o`, and return to IDLE the next cycle.
- Write path: a `FIFO_RD_LAT`-deep shift register carries the read strobe and its address. `Write_Enable_o` and `addr_o` are the outputs of that shift register, which aligns them with the FIFO data that the memories take directly.
- `count_o` increments on each write.
  - In circular mode it resets to 0 on the cycle after the write to address len-1. `wrap_o` pulses on that write.
- `start_i` is ignored outside IDLE. `mode_i`, `len_i` and `ch_en_i` changing mid-capture have no effect.
- `ch_en_i` = 0 (all channels disabled): reads proceed at one per cycle, unthrottled.

## Timing
- Reset (asynchronous, any state): state = IDLE. All outputs are 0, including `addr_o` and `count_o`. The in-flight pipeline is cleared and pending writes are discarded.
- Start to first possible `Read_Enable_o`: 1 cycle (the first RUN cycle).
- `Read_Enable_o` to `Write_Enable_o`: exactly `FIFO_RD_LAT` cycles, with the same address.
- Throughput: 1 word per cycle while all enabled FIFOs are non-empty.
- One-shot, uninterrupted: `done_o` asserts `FIFO_RD_LAT`+1 cycles after the last read. `busy_o` falls in the same cycle.
- A `stop_i` cycle never issues a read. Reads already in flight always complete their writes.
- Addresses never exceed len-1. No write occurs outside RUN/DRAIN.

## Test plan
- One-shot, NCH=2, len=8, both FIFOs always non-empty: 8 reads on consecutive cycles, writes to addresses 0..7 one cycle later, `done_o` 2 cycles after the last read, `count_o` = 8.
- Throttling: `empty_i[1]` toggles every other cycle with `ch_en_i` = 2'b11 -> reads only in cycles where both flags are low, addresses stay contiguous, 8 writes total. The same stimulus with `ch_en_i` = 2'b01 -> uninterrupted 8-cycle burst.
- Circular, len=4, 10 reads, then `stop_i` -> addresses 0,1,2,3,0,1,2,3,0,1. `wrap_o` pulses on the two writes to address 3. `done_o` fires once after the final write.
- len=0 start -> no reads or writes; `busy_o` high for 1 cycle, then a 1-cycle `done_o`.
- `FIFO_RD_LAT`=2, one-shot len=5 -> each write lags its read by 2 cycles. `stop_i` after the 3rd read -> exactly 3 writes, then `done_o`.
- `rstn` asserted mid-RUN with a read in flight -> all outputs 0 immediately, no subsequent write. A new `start_i` after release restarts from address 0.

Source files
------------

// File: rtl/sink_nch_ctrl.sv
// Drains NCH lock-stepped FIFOs into sample memories: one-shot or circular capture, abortable.
// Write lags read by FIFO_RD_LAT cycles; reads stall while any enabled FIFO is empty.
module sink_nch_ctrl #(
  parameter int NCH         = 2,
  parameter int ADDR_WIDTH  = 20,
  parameter int FIFO_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  mode_i,
  input  logic [NCH-1:0]        ch_en_i,
  input  logic [NCH-1:0]        empty_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  output logic                  Read_Enable_o,
  output logic                  Write_Enable_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH-1:0] count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  wrap_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic [NCH-1:0]          ch_en_q, ch_en_d;

  logic [FIFO_RD_LAT-1:0]                 vld_q;
  logic [FIFO_RD_LAT-1:0][ADDR_WIDTH-1:0] adr_q;

  logic                    stall;
  logic                    quota_ok;
  logic                    rd_en;
  logic                    last_rd;
  logic                    pending;
  logic [ADDR_WIDTH-1:0]   len_m1;

  assign len_m1   = len_q - ADDR_WIDTH'(1);
  assign stall    = |(empty_i & ch_en_q);
  // A zero-length capture must never read, even in circular mode.
  assign quota_ok = (len_q != '0) && (mode_q || (rd_cnt_q < len_q));
  assign rd_en    = (state_q == S_RUN) && !stop_i && !stall && quota_ok;
  assign last_rd  = (rd_cnt_q == len_m1);

  assign Read_Enable_o  = rd_en;
  assign Write_Enable_o = vld_q[FIFO_RD_LAT-1];
  assign addr_o         = adr_q[FIFO_RD_LAT-1];
  assign count_o        = cnt_q;
  assign busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o         = (state_q == S_DONE);
  assign wrap_o         = Write_Enable_o && mode_q && (addr_o == len_m1);

  // Reads still to land next cycle: every stage except the output one.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < FIFO_RD_LAT - 1; i++) begin
      pending = pending | vld_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    mode_d   = mode_q;
    ch_en_d  = ch_en_q;
    rd_cnt_d = rd_cnt_q;
    cnt_d    = cnt_q;

    if (Write_Enable_o) begin
      cnt_d = wrap_o ? '0 : cnt_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d    = len_i;
          mode_d   = mode_i;
          ch_en_d  = ch_en_i;
          rd_cnt_d = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (len_q == '0) begin
          state_d = S_DONE;
        end else if (stop_i) begin
          state_d = S_DRAIN;
        end else if (rd_en) begin
          if (mode_q) begin
            rd_cnt_d = last_rd ? '0 : rd_cnt_q + ADDR_WIDTH'(1);
          end else begin
            rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
            if (last_rd) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!pending) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      mode_q   <= 1'b0;
      ch_en_q  <= '0;
      rd_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      ch_en_q  <= ch_en_d;
      rd_cnt_q <= rd_cnt_d;
      cnt_q    <= cnt_d;
    end
  end

  // Strobe/address delay line aligning the write with FIFO output data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      adr_q <= '0;
    end else begin
      vld_q[0] <= rd_en;
      adr_q[0] <= rd_en ? rd_cnt_q : '0;
      for (int i = 1; i < FIFO_RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sink_nch_ctrl.sv
// Bench for sink_nch_ctrl: two instances (read latency 1 and 2) share stimulus;
// each scenario is checked cycle by cycle against a transaction-level model.
module tb_sink_nch_ctrl;
  localparam int NCH = 2;
  localparam int AW  = 20;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start_i, stop_i, mode_i;
  logic [NCH-1:0] ch_en_i, empty_i;
  logic [AW-1:0] len_i;

  logic          re1, we1, busy1, done1, wrap1;
  logic [AW-1:0] addr1, cnt1;
  logic          re2, we2, busy2, done2, wrap2;
  logic [AW-1:0] addr2, cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sink_nch_ctrl #(.NCH(NCH), .ADDR_WIDTH(AW), .FIFO_RD_LAT(1)) u_lat1 (
    .clk(clk), .rstn(rstn), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
    .ch_en_i(ch_en_i), .empty_i(empty_i), .len_i(len_i),
    .Read_Enable_o(re1), .Write_Enable_o(we1), .addr_o(addr1), .count_o(cnt1),
    .busy_o(busy1), .done_o(done1), .wrap_o(wrap1));

  sink_nch_ctrl #(.NCH(NCH), .ADDR_WIDTH(AW), .FIFO_RD_LAT(2)) u_lat2 (
    .clk(clk), .rstn(rstn), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
    .ch_en_i(ch_en_i), .empty_i(empty_i), .len_i(len_i),
    .Read_Enable_o(re2), .Write_Enable_o(we2), .addr_o(addr2), .count_o(cnt2),
    .busy_o(busy2), .done_o(done2), .wrap_o(wrap2));

  typedef struct packed {
    logic          re, we, busy, done, wrap;
    logic [AW-1:0] addr, cnt;
  } obs_t;

  function automatic obs_t get_obs(input int lat);
    obs_t o;
    if (lat == 2) o = '{re2, we2, busy2, done2, wrap2, addr2, cnt2};
    else          o = '{re1, we1, busy1, done1, wrap1, addr1, cnt1};
    return o;
  endfunction

  // Runs one capture on the chosen instance. Model: read k goes to address
  // k (or k mod len), lands exactly lat cycles later; done follows the last write.
  task automatic run_capture(input int lat, input bit mode, input int len,
                             input logic [NCH-1:0] en, input int pat, input int stop_after,
                             output int n_wr, output int n_wrap);
    int   n_rd, last_rd, done_cyc, c, exp_adr, exp_cnt;
    int   wq_due[$];
    int   wq_adr[$];
    bit   stopped, running, exp_re, exp_we, exp_wrap, exp_busy, exp_done;
    obs_t o;
    n_rd = 0; last_rd = -1; done_cyc = (len == 0) ? 2 : -1; stopped = 0;
    n_wr = 0; n_wrap = 0;
    @(negedge clk);
    start_i = 1'b1; mode_i = mode; len_i = AW'(len); ch_en_i = en; stop_i = 1'b0; empty_i = '0;
    @(negedge clk);
    start_i = 1'b0; mode_i = ~mode; len_i = AW'($urandom); ch_en_i = ~en;
    c = 1;
    while (c < 3000) begin
      running = !stopped && len != 0 && (mode || n_rd < len);
      case (pat)
        0: empty_i = '0;
        1: begin empty_i = '0; empty_i[1] = c[0]; end
        default: empty_i = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
      endcase
      stop_i = running && stop_after >= 0 && n_rd == stop_after;
      #1;
      o = get_obs(lat);
      exp_re = running && !stop_i && ((empty_i & en) == '0);
      exp_we = wq_due.size() > 0 && wq_due[0] == c;
      exp_adr = exp_we ? wq_adr[0] : 0;
      exp_wrap = exp_we && mode && exp_adr == len - 1;
      exp_cnt = (mode && len != 0) ? (n_wr % len) : n_wr;
      if (running && stop_i) begin
        stopped = 1;
        done_cyc = (c + 2 > last_rd + lat + 1) ? c + 2 : last_rd + lat + 1;
      end
      if (exp_re && !mode && n_rd + 1 == len) done_cyc = c + lat + 1;
      exp_busy = (done_cyc < 0) || (c < done_cyc);
      exp_done = (c == done_cyc);

      n_checks += 6;
      if (o.re !== exp_re) begin
        n_fail++; $display("FAIL read_enable lat%0d cyc%0d: got %b want %b", lat, c, o.re, exp_re);
      end
      if (o.we !== exp_we) begin
        n_fail++; $display("FAIL write_enable lat%0d cyc%0d: got %b want %b", lat, c, o.we, exp_we);
      end
      if (o.wrap !== exp_wrap) begin
        n_fail++; $display("FAIL wrap lat%0d cyc%0d: got %b want %b", lat, c, o.wrap, exp_wrap);
      end
      if (o.busy !== exp_busy) begin
        n_fail++; $display("FAIL busy lat%0d cyc%0d: got %b want %b", lat, c, o.busy, exp_busy);
      end
      if (o.done !== exp_done) begin
        n_fail++; $display("FAIL done lat%0d cyc%0d: got %b want %b", lat, c, o.done, exp_done);
      end
      if (o.cnt !== AW'(exp_cnt)) begin
        n_fail++; $display("FAIL count lat%0d cyc%0d: got %0d want %0d", lat, c, o.cnt, exp_cnt);
      end
      if (exp_we) begin
        n_checks++;
        if (o.addr !== AW'(exp_adr)) begin
          n_fail++; $display("FAIL addr lat%0d cyc%0d: got %0d want %0d", lat, c, o.addr, exp_adr);
        end
        void'(wq_due.pop_front());
        void'(wq_adr.pop_front());
        n_wr++;
        if (exp_wrap) n_wrap++;
      end
      if (exp_re) begin
        wq_due.push_back(c + lat);
        wq_adr.push_back(mode ? n_rd % len : n_rd);
        last_rd = c;
        n_rd++;
      end
      if (done_cyc >= 0 && c > done_cyc) break;
      @(negedge clk);
      c++;
    end
    if (c >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL capture_timeout lat%0d: got %0d cycles want done", lat, c);
    end
    stop_i = 1'b0; empty_i = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    obs_t o;
    rstn = 1'b0; start_i = 1'b0; stop_i = 1'b0; mode_i = 1'b0;
    ch_en_i = '0; empty_i = '0; len_i = '0;
    #3;
    for (int l = 1; l <= 2; l++) begin
      o = get_obs(l);
      n_checks++;
      if (o !== '0) begin
        n_fail++; $display("FAIL reset_outputs lat%0d: got %h want 0", l, o);
      end
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_oneshot;
    int nw, nwp;
    obs_t o;
    run_capture(1, 1'b0, 8, 2'b11, 0, -1, nw, nwp);
    o = get_obs(1);
    n_checks += 2;
    if (nw != 8) begin n_fail++; $display("FAIL oneshot_writes: got %0d want 8", nw); end
    if (o.cnt !== AW'(8)) begin n_fail++; $display("FAIL oneshot_count: got %0d want 8", o.cnt); end
  endtask

  task automatic test_throttle;
    int nw, nwp;
    run_capture(1, 1'b0, 8, 2'b11, 1, -1, nw, nwp);
    n_checks++;
    if (nw != 8) begin n_fail++; $display("FAIL throttle_both_writes: got %0d want 8", nw); end
    run_capture(1, 1'b0, 8, 2'b01, 1, -1, nw, nwp);
    n_checks++;
    if (nw != 8) begin n_fail++; $display("FAIL throttle_masked_writes: got %0d want 8", nw); end
    run_capture(2, 1'b0, 6, 2'b00, 2, -1, nw, nwp);
    n_checks++;
    if (nw != 6) begin n_fail++; $display("FAIL throttle_nomask_writes: got %0d want 6", nw); end
  endtask

  task automatic test_circular;
    int nw, nwp;
    run_capture(1, 1'b1, 4, 2'b11, 0, 10, nw, nwp);
    n_checks += 2;
    if (nw != 10) begin n_fail++; $display("FAIL circular_writes: got %0d want 10", nw); end
    if (nwp != 2) begin n_fail++; $display("FAIL circular_wraps: got %0d want 2", nwp); end
  endtask

  task automatic test_len0;
    int nw, nwp;
    run_capture(1, 1'b0, 0, 2'b11, 0, -1, nw, nwp);
    n_checks++;
    if (nw != 0) begin n_fail++; $display("FAIL len0_writes: got %0d want 0", nw); end
  endtask

  task automatic test_lat2;
    int nw, nwp;
    run_capture(2, 1'b0, 5, 2'b11, 0, -1, nw, nwp);
    n_checks++;
    if (nw != 5) begin n_fail++; $display("FAIL lat2_writes: got %0d want 5", nw); end
    run_capture(2, 1'b0, 5, 2'b11, 0, 3, nw, nwp);
    n_checks++;
    if (nw != 3) begin n_fail++; $display("FAIL lat2_stop_writes: got %0d want 3", nw); end
  endtask

  task automatic test_random;
    int nw, nwp, lat, len, sa;
    bit mode;
    for (int k = 0; k < 16; k++) begin
      lat  = $urandom_range(1, 2);
      mode = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 12);
      if (mode) sa = $urandom_range(0, 3 * len);
      else      sa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
      run_capture(lat, mode, len, NCH'($urandom), 2, sa, nw, nwp);
    end
  endtask

  task automatic test_reset_midrun;
    int nw, nwp;
    bit seen;
    obs_t o;
    @(negedge clk);
    start_i = 1'b1; mode_i = 1'b0; len_i = AW'(8); ch_en_i = 2'b11; empty_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (re2 === 1'b1) seen = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midrun_read_timeout: got no read want read"); end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    for (int l = 1; l <= 2; l++) begin
      o = get_obs(l);
      n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL midrun_reset_outputs lat%0d: got %h want 0", l, o); end
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (we1 !== 1'b0 || we2 !== 1'b0 || busy2 !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_idle cyc%0d: got we=%b%b busy=%b want 0", i, we1, we2, busy2);
      end
      @(negedge clk);
    end
    run_capture(2, 1'b0, 5, 2'b11, 0, -1, nw, nwp);
    n_checks++;
    if (nw != 5) begin n_fail++; $display("FAIL restart_writes: got %0d want 5", nw); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_throttle();
    test_circular();
    test_len0();
    test_lat2();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
